// File: rtl/hamming_pkg.sv
// hamming_pkg: shared widths, FSM states and Hamming(11,7) parity positions
package hamming_pkg;
  localparam int D_W = 7;
  localparam int CW_W = 11;
  localparam int FRAME_W = 29;
  localparam logic [4:0] LAST_BIT = 5'(FRAME_W - 1);
  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int P4_POS = 3;
  localparam int P8_POS = 7;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/hamming11_enc.sv
// hamming11_enc: combinational Hamming(11,7) encoder, cw[0] is position 1
module hamming11_enc
  import hamming_pkg::*;
(
  input  logic [D_W-1:0]  d,
  output logic [CW_W-1:0] cw
);
  always_comb begin
    cw = {d[6:4], 1'b0, d[3:1], 1'b0, d[0], 2'b00};
    cw[P1_POS] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    cw[P2_POS] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    cw[P4_POS] = d[1] ^ d[2] ^ d[3];
    cw[P8_POS] = d[4] ^ d[5] ^ d[6];
  end
endmodule

// File: rtl/hamming_frame_tx.sv
// hamming_frame_tx: encodes two 7-bit halves plus column parity into a 29-bit frame, sent LSB first
module hamming_frame_tx
  import hamming_pkg::*;
#(
  parameter bit INJ_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*D_W-1:0]     in_data,
  input  logic [FRAME_W-1:0]   inj_mask,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 ser_data,
  output logic                 ser_valid,
  input  logic                 ser_ready,
  output logic                 ser_last,
  output logic [7:0]           frame_count
);
  state_t state, state_n;
  logic [FRAME_W-1:0] frame_reg, frame;
  logic [4:0] cnt;
  logic [CW_W-1:0] cw0, cw1;
  logic done;
  hamming11_enc u_enc0 (.d(in_data[D_W-1:0]), .cw(cw0));
  hamming11_enc u_enc1 (.d(in_data[2*D_W-1:D_W]), .cw(cw1));
  assign frame = {in_data[2*D_W-1:D_W] ^ in_data[D_W-1:0], cw1, cw0} ^ (INJ_EN ? inj_mask : '0);
  assign done = state == SHIFT && ser_ready && cnt == LAST_BIT;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? SHIFT : IDLE) : (done ? IDLE : SHIFT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      frame_reg <= '0;
      cnt <= '0;
      frame_count <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        frame_reg <= frame;
        cnt <= '0;
      end else if (state == SHIFT && ser_ready) begin
        frame_reg <= frame_reg >> 1;
        cnt <= done ? 5'd0 : cnt + 5'd1;
        if (done) frame_count <= frame_count + 8'd1;
      end
    end
  end
  assign in_ready = state == IDLE;
  assign ser_valid = state == SHIFT;
  assign ser_data = frame_reg[0];
  assign ser_last = state == SHIFT && cnt == LAST_BIT;
endmodule

// File: tb/tb_hamming_frame_tx.sv
// tb_hamming_frame_tx: vector table plus randomized back-to-back frames against a positional Hamming model
module tb_hamming_frame_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [13:0] in_data = '0;
  logic [28:0] inj_mask = '0;
  logic in_valid = 1'b0;
  logic ser_ready = 1'b1;
  logic in_ready0, ser_data0, ser_valid0, ser_last0;
  logic in_ready1, ser_data1, ser_valid1, ser_last1;
  logic [7:0] fc0, fc1;
  int checks = 0;
  int errors = 0;
  int exp_fc = 0;

  always #5 clk = ~clk;

  hamming_frame_tx #(.INJ_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .inj_mask(inj_mask), .in_valid(in_valid),
    .in_ready(in_ready0), .ser_data(ser_data0), .ser_valid(ser_valid0), .ser_ready(ser_ready),
    .ser_last(ser_last0), .frame_count(fc0)
  );
  hamming_frame_tx #(.INJ_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .inj_mask(inj_mask), .in_valid(in_valid),
    .in_ready(in_ready1), .ser_data(ser_data1), .ser_valid(ser_valid1), .ser_ready(ser_ready),
    .ser_last(ser_last1), .frame_count(fc1)
  );

  // Data bits fill the non-power-of-two positions; each parity at 2^k covers positions with bit k set.
  function automatic logic [10:0] enc(input logic [6:0] d);
    logic [10:0] cw;
    logic par;
    int j;
    cw = '0;
    j = 0;
    for (int pos = 1; pos <= 11; pos++)
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = d[j];
        j++;
      end
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int pos = 1; pos <= 11; pos++)
        if ((pos & (1 << k)) != 0 && pos != (1 << k)) par = par ^ cw[pos-1];
      cw[(1<<k)-1] = par;
    end
    return cw;
  endfunction

  function automatic logic [28:0] model(input logic [13:0] d, input logic [28:0] m, input bit en);
    return {d[13:7] ^ d[6:0], enc(d[13:7]), enc(d[6:0])} ^ (en ? m : 29'h0);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_frame(input logic [13:0] d, input logic [28:0] m, input int stall_at,
                           input int stall_len, input bit noisy);
    logic [28:0] e0, e1, g0, g1;
    int cyc, k, st;
    bit hs_ok, last_ok, hold_ok;
    e0 = model(d, m, 1'b1);
    e1 = model(d, m, 1'b0);
    @(negedge clk);
    in_data = d;
    inj_mask = m;
    in_valid = 1'b1;
    ser_ready = 1'b1;
    @(posedge clk);
    cyc = 0; k = 0; st = 0; g0 = '0; g1 = '0;
    hs_ok = 1'b1; last_ok = 1'b1; hold_ok = 1'b1;
    while (k < 29 && cyc < 200) begin
      @(negedge clk);
      in_valid = noisy ? 1'($urandom) : 1'b0;
      if (noisy) begin
        in_data = 14'($urandom);
        inj_mask = 29'($urandom);
      end
      if (in_ready0 || in_ready1 || !ser_valid0 || !ser_valid1) hs_ok = 1'b0;
      if (ser_last0 !== (k == 28) || ser_last1 !== (k == 28)) last_ok = 1'b0;
      if (k == stall_at && st < stall_len) begin
        if (ser_data0 !== e0[k] || ser_data1 !== e1[k]) hold_ok = 1'b0;
        ser_ready = 1'b0;
        st++;
      end else begin
        ser_ready = 1'b1;
        g0[k] = ser_data0;
        g1[k] = ser_data1;
        k++;
      end
      @(posedge clk);
      cyc++;
    end
    #1;
    exp_fc = (exp_fc + 1) % 256;
    check("frame_inj", 32'(g0), 32'(e0));
    check("frame_noinj", 32'(g1), 32'(e1));
    check("cycles", cyc, 29 + stall_len);
    check("frame_count0", 32'(fc0), exp_fc);
    check("frame_count1", 32'(fc1), exp_fc);
    check("in_ready_after", {30'b0, in_ready0, ser_valid0}, 32'h2);
    check("handshake_shift", 32'(hs_ok), 1);
    check("ser_last", 32'(last_ok), 1);
    if (stall_len > 0) check("stall_hold", 32'(hold_ok), 1);
  endtask

  typedef struct {
    logic [13:0] d;
    logic [28:0] m;
    int stall_at;
    int stall_len;
    logic [28:0] f0;
    logic [28:0] f1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{14'h0001, 29'h0, -1, 0, 29'h0040_0007, 29'h0040_0007};
    vecs[1] = '{14'h3FFF, 29'h0, -1, 0, 29'h003F_FFFF, 29'h003F_FFFF};
    vecs[2] = '{14'h0000, 29'h1, -1, 0, 29'h0000_0001, 29'h0000_0000};
    vecs[3] = '{14'h0001, 29'h0, 10, 5, 29'h0040_0007, 29'h0040_0007};
    vecs[4] = '{14'h0000, 29'h1000_0000, -1, 0, 29'h1000_0000, 29'h0000_0000};

    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready0}, 1);
    check("rst_outputs", {29'b0, ser_valid0, ser_data0, ser_last0}, 0);
    check("rst_frame_count", 32'(fc0), 0);
    rst_n = 1'b1;

    @(negedge clk);
    in_data = 14'h3FFF;
    inj_mask = '0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    check("pre_abort_bit15", {30'b0, ser_valid0, ser_data0}, 32'h3);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", {31'b0, in_ready0}, 1);
    check("abort_outputs", {29'b0, ser_valid0, ser_data0, ser_last0}, 0);
    check("abort_frame_count", 32'(fc0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      check("model_vs_table_inj", 32'(model(vecs[i].d, vecs[i].m, 1'b1)), 32'(vecs[i].f0));
      check("model_vs_table_noinj", 32'(model(vecs[i].d, vecs[i].m, 1'b0)), 32'(vecs[i].f1));
      run_frame(vecs[i].d, vecs[i].m, vecs[i].stall_at, vecs[i].stall_len, 1'b0);
    end

    for (int i = 0; i < 256; i++)
      run_frame(14'($urandom), 29'($urandom), -1, 0, 1'b1);
    check("wrap_value", 32'(fc0), 32'((5 + 256) % 256));
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
